// File: rtl/wb_mire_writer.sv
// Wishbone master that fills the frame-buffer BlockRAM with the deterministic "mire" pattern.
// Optional macro MIRE_VERIFY_EN adds a full read-back pass and the o_err_cnt mismatch counter.
module wb_mire_writer #(
  parameter int NUM_WORDS = 2048,
  parameter int ADR_WIDTH = 11
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [ADR_WIDTH-1:0] o_wbm_adr,
  output logic [31:0]          o_wbm_dat,
  input  logic [31:0]          i_wbm_dat,
  output logic                 o_wbm_we,
  output logic                 o_wbm_stb,
  output logic                 o_wbm_cyc,
  output logic [3:0]           o_wbm_sel,
  output logic [2:0]           o_wbm_cti,
  output logic [1:0]           o_wbm_bte,
  input  logic                 i_wbm_ack,
  input  logic                 i_wbm_err,
  input  logic                 i_wbm_rty
`ifdef MIRE_VERIFY_EN
  ,
  output logic [15:0]          o_err_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_VERIFY_REQ,
    S_VERIFY_GAP,
    S_DONE
  } state_t;

  localparam logic [ADR_WIDTH-1:0] LAST_IDX = ADR_WIDTH'(NUM_WORDS - 1);
  localparam logic [ADR_WIDTH-1:0] IDX_ONE  = ADR_WIDTH'(1);
  localparam int                   LO_W     = (ADR_WIDTH < 8) ? ADR_WIDTH : 8;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [ADR_WIDTH-1:0] r_idx;
  logic [ADR_WIDTH-1:0] w_idx_nxt;
  logic [7:0]           w_lo;
  logic [31:0]          w_pattern;
  logic                 w_unused;

`ifdef MIRE_VERIFY_EN
  logic [15:0] r_err_cnt;
  logic [15:0] w_err_cnt_nxt;

  assign o_err_cnt = r_err_cnt;
  assign w_unused  = i_wbm_err ^ i_wbm_rty;
`else
  assign w_unused  = ^{i_wbm_err, i_wbm_rty, i_wbm_dat};
`endif

  // The pattern only depends on the low byte of the word index.
  assign w_lo      = 8'(r_idx[LO_W-1:0]);
  assign w_pattern = {8'h00, w_lo, ~w_lo, w_lo ^ 8'hA5};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
`ifdef MIRE_VERIFY_EN
      r_err_cnt <= '0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
`ifdef MIRE_VERIFY_EN
      r_err_cnt <= w_err_cnt_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
`ifdef MIRE_VERIFY_EN
    w_err_cnt_nxt = r_err_cnt;
`endif
    case (r_state)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          w_state_nxt   = S_WRITE;
          w_idx_nxt     = '0;
`ifdef MIRE_VERIFY_EN
          w_err_cnt_nxt = '0;
`endif
        end
      end
      S_WRITE: begin
        if (i_wbm_ack) begin
          if (r_idx == LAST_IDX) begin
            w_idx_nxt   = '0;
`ifdef MIRE_VERIFY_EN
            w_state_nxt = S_VERIFY_REQ;
`else
            w_state_nxt = S_DONE;
`endif
          end else begin
            w_idx_nxt = r_idx + IDX_ONE;
          end
        end
      end
`ifdef MIRE_VERIFY_EN
      S_VERIFY_REQ: begin
        if (i_wbm_ack) begin
          if ((i_wbm_dat != w_pattern) && (r_err_cnt != 16'hFFFF)) begin
            w_err_cnt_nxt = r_err_cnt + 16'd1;
          end
          w_state_nxt = S_VERIFY_GAP;
        end
      end
      // One idle cycle so the slave's registered read ack cannot stream into the next word.
      S_VERIFY_GAP: begin
        if (r_idx == LAST_IDX) begin
          w_idx_nxt   = '0;
          w_state_nxt = S_DONE;
        end else begin
          w_idx_nxt   = r_idx + IDX_ONE;
          w_state_nxt = S_VERIFY_REQ;
        end
      end
`endif
      default: begin
        w_state_nxt = S_IDLE;
        w_idx_nxt   = '0;
      end
    endcase
  end

  assign o_wbm_stb = (r_state == S_WRITE) || (r_state == S_VERIFY_REQ);
  assign o_wbm_cyc = o_wbm_stb;
  assign o_wbm_we  = (r_state == S_WRITE);
  assign o_wbm_adr = r_idx;
  assign o_wbm_dat = o_wbm_we ? w_pattern : 32'h0;
  assign o_wbm_sel = 4'hF;
  assign o_wbm_cti = 3'b000;
  assign o_wbm_bte = 2'b00;
  assign o_busy    = (r_state == S_WRITE) || (r_state == S_VERIFY_REQ) ||
                     (r_state == S_VERIFY_GAP);
  assign o_done    = (r_state == S_DONE);

endmodule

// File: tb/tb_wb_mire_writer.sv
// Testbench for wb_mire_writer: BlockRAM-like slave (combinational write ack, registered read ack)
// plus a pattern/latency reference model; compile with MIRE_VERIFY_EN to exercise the read-back pass.
module tb_wb_mire_writer;

  localparam int NW = 16;
  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy;
  logic          done;
  logic [AW-1:0] adr;
  logic [31:0]   datMs;
  logic [31:0]   datSm;
  logic          we;
  logic          stb;
  logic          cyc;
  logic [3:0]    sel;
  logic [2:0]    cti;
  logic [1:0]    bte;
  logic          ack;
`ifdef MIRE_VERIFY_EN
  logic [15:0]   errCnt;
`endif

  int testsRun    = 0;
  int testsFailed = 0;

  // Slave model state.
  logic [31:0]   mem [0:NW-1];
  logic [NW-1:0] corruptMask = '0;
  logic          rdAck = 1'b0;
  logic          forceAck = 1'b0;
  logic [AW-1:0] stallAdr = '0;
  int            stallLen = 0;
  int            stallUsed = 0;
  logic          writeStall;
  logic [AW-1:0] logAdr [$];
  logic [31:0]   logDat [$];

  always #5 clk = ~clk;

  wb_mire_writer #(.NUM_WORDS(NW), .ADR_WIDTH(AW)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_start   (start),
    .o_busy    (busy),
    .o_done    (done),
    .o_wbm_adr (adr),
    .o_wbm_dat (datMs),
    .i_wbm_dat (datSm),
    .o_wbm_we  (we),
    .o_wbm_stb (stb),
    .o_wbm_cyc (cyc),
    .o_wbm_sel (sel),
    .o_wbm_cti (cti),
    .o_wbm_bte (bte),
    .i_wbm_ack (ack),
    .i_wbm_err (1'b0),
    .i_wbm_rty (1'b0)
`ifdef MIRE_VERIFY_EN
    ,
    .o_err_cnt (errCnt)
`endif
  );

  // Writes are acked combinationally unless a wait state is being injected on stallAdr.
  assign writeStall = (stallUsed < stallLen) && (adr == stallAdr);
  assign ack = (stb && we && !writeStall) || rdAck || forceAck;

  // Slave memory, write log and one-cycle-latency read path (returns 0 on corrupted words).
  always @(posedge clk) begin
    if (stb && we && !writeStall) begin
      mem[adr[3:0]] <= datMs;
      logAdr.push_back(adr);
      logDat.push_back(datMs);
    end
    if (!busy) stallUsed <= 0;
    else if (stb && we && writeStall) stallUsed <= stallUsed + 1;
    rdAck <= stb && !we && !rdAck;
    datSm <= corruptMask[adr[3:0]] ? 32'h0 : mem[adr[3:0]];
  end

  function automatic logic [31:0] mireWord(input int i);
    logic [7:0] b;
    b = i[7:0];
    return {8'h00, b, ~b, b ^ 8'hA5};
  endfunction

  function automatic int expLatency(input int stalls);
`ifdef MIRE_VERIFY_EN
    return NW + 1 + stalls + 3 * NW;
`else
    return NW + 1 + stalls;
`endif
  endfunction

  task automatic applyReset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Pulses start at a negedge and counts cycles until done rises; -1 if the budget expires.
  task automatic applyStimulus(output int cycles, output logic firstStb);
    start = 1'b1;
    cycles = -1;
    firstStb = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start = 1'b0;
        firstStb = stb && we && (adr == '0) && (datMs == mireWord(0));
      end
      if (done) begin
        cycles = c;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    applyReset();
    forceAck = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      testsRun++;
      if ({stb, done, busy, adr} !== {1'b0, 1'b0, 1'b0, {AW{1'b0}}}) begin
        testsFailed++;
        $display("[TB] FAIL reset_idle cycle %0d: stb=%b done=%b busy=%b adr=%0d, want all 0",
                 c, stb, done, busy, adr);
      end
    end
    forceAck = 1'b0;
    testsRun++;
    if ({cyc, sel, cti, bte} !== {stb, 4'hF, 3'b000, 2'b00}) begin
      testsFailed++;
      $display("[TB] FAIL bus_constants: cyc=%b sel=%h cti=%0d bte=%0d, want cyc=stb sel=F cti=0 bte=0",
               cyc, sel, cti, bte);
    end
`ifdef MIRE_VERIFY_EN
    testsRun++;
    if (errCnt !== 16'h0) begin
      testsFailed++;
      $display("[TB] FAIL reset_err_cnt: got %0d, want 0", errCnt);
    end
`endif
  endtask

  task automatic test_basic_fill();
    int lat;
    logic first;
    logAdr.delete();
    logDat.delete();
    applyStimulus(lat, first);
    testsRun++;
    if (first !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL first_stb: got stb=%b we=%b adr=%0d dat=%h, want write of P(0) one cycle after start",
               stb, we, adr, datMs);
    end
    testsRun++;
    if (lat != expLatency(0)) begin
      testsFailed++;
      $display("[TB] FAIL fill_latency: got %0d cycles, want %0d", lat, expLatency(0));
    end
    testsRun++;
    if (logAdr.size() != NW) begin
      testsFailed++;
      $display("[TB] FAIL fill_count: got %0d writes, want %0d", logAdr.size(), NW);
    end
    for (int i = 0; i < logAdr.size() && i < NW; i++) begin
      testsRun++;
      if (logAdr[i] !== AW'(i) || logDat[i] !== mireWord(i)) begin
        testsFailed++;
        $display("[TB] FAIL fill_word %0d: got adr=%0d dat=%h, want adr=%0d dat=%h",
                 i, logAdr[i], logDat[i], i, mireWord(i));
      end
    end
    testsRun++;
    if (mem[5] !== 32'h0005FAA0) begin
      testsFailed++;
      $display("[TB] FAIL mem_word5: got %h, want 0005FAA0", mem[5]);
    end
    testsRun++;
    if ({done, busy, stb} !== 3'b100) begin
      testsFailed++;
      $display("[TB] FAIL done_state: got done=%b busy=%b stb=%b, want 1 0 0", done, busy, stb);
    end
`ifdef MIRE_VERIFY_EN
    testsRun++;
    if (errCnt !== 16'h0) begin
      testsFailed++;
      $display("[TB] FAIL clean_verify: got err_cnt=%0d, want 0", errCnt);
    end
`endif
  endtask

  task automatic test_wait_states();
    int lat;
    int seenAt7;
    logAdr.delete();
    logDat.delete();
    stallAdr = AW'(7);
    stallLen = 3;
    seenAt7 = 0;
    lat = -1;
    start = 1'b1;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (stb && we && adr == AW'(7)) begin
        seenAt7++;
        testsRun++;
        if (datMs !== 32'h0007F8A2) begin
          testsFailed++;
          $display("[TB] FAIL wait_hold cycle %0d: got dat=%h, want 0007F8A2", seenAt7, datMs);
        end
      end
      if (done) begin
        lat = c;
        break;
      end
    end
    stallLen = 0;
    testsRun++;
    if (seenAt7 != 4) begin
      testsFailed++;
      $display("[TB] FAIL wait_hold_len: adr=7 held %0d cycles, want 4", seenAt7);
    end
    testsRun++;
    if (lat != expLatency(3)) begin
      testsFailed++;
      $display("[TB] FAIL wait_latency: got %0d cycles, want %0d", lat, expLatency(3));
    end
    testsRun++;
    if (logAdr.size() != NW) begin
      testsFailed++;
      $display("[TB] FAIL wait_count: got %0d writes, want %0d", logAdr.size(), NW);
    end
  endtask

  task automatic test_random_stalls();
    int lat;
    logic first;
    int len;
    for (int it = 0; it < 4; it++) begin
      repeat ($urandom_range(1, 4)) @(negedge clk);
      len = $urandom_range(0, 5);
      stallAdr = AW'($urandom_range(0, NW - 1));
      stallLen = len;
      logAdr.delete();
      logDat.delete();
      applyStimulus(lat, first);
      stallLen = 0;
      testsRun++;
      if (lat != expLatency(len)) begin
        testsFailed++;
        $display("[TB] FAIL rand_latency it %0d: got %0d cycles, want %0d (stall %0d on adr %0d)",
                 it, lat, expLatency(len), len, stallAdr);
      end
      for (int i = 0; i < NW; i++) begin
        testsRun++;
        if (i >= logAdr.size() || logAdr[i] !== AW'(i) || logDat[i] !== mireWord(i)) begin
          testsFailed++;
          $display("[TB] FAIL rand_word it %0d idx %0d: log size %0d, want adr=%0d dat=%h",
                   it, i, logAdr.size(), i, mireWord(i));
          break;
        end
      end
    end
  endtask

  task automatic test_back_to_back_start_and_reset();
    int lat;
    logic first;
    logic pulsed;
    logic hit;
    pulsed = 1'b0;
    hit = 1'b0;
    logAdr.delete();
    logDat.delete();
    start = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (!pulsed && stb && adr == AW'(4)) begin
        start = 1'b1;
        pulsed = 1'b1;
      end
      if (stb && adr == AW'(9)) begin
        rst = 1'b1;
        hit = 1'b1;
        break;
      end
    end
    start = 1'b0;
    testsRun++;
    if (!hit) begin
      testsFailed++;
      $display("[TB] FAIL reach_word9: got no stb at adr 9 in budget, want it reached");
    end
    @(negedge clk);
    rst = 1'b0;
    testsRun++;
    if ({stb, busy, done, adr} !== {1'b0, 1'b0, 1'b0, {AW{1'b0}}}) begin
      testsFailed++;
      $display("[TB] FAIL midfill_reset: got stb=%b busy=%b done=%b adr=%0d, want all 0",
               stb, busy, done, adr);
    end
    testsRun++;
    if (logAdr.size() != 10) begin
      testsFailed++;
      $display("[TB] FAIL no_restart_count: got %0d writes before reset, want 10", logAdr.size());
    end
    for (int i = 0; i < logAdr.size(); i++) begin
      testsRun++;
      if (logAdr[i] !== AW'(i)) begin
        testsFailed++;
        $display("[TB] FAIL no_restart_seq %0d: got adr=%0d, want %0d", i, logAdr[i], i);
        break;
      end
    end
    logAdr.delete();
    logDat.delete();
    applyStimulus(lat, first);
    testsRun++;
    if (!first || lat != expLatency(0) || logAdr.size() != NW) begin
      testsFailed++;
      $display("[TB] FAIL refill_after_reset: got first=%b lat=%0d writes=%0d, want 1 %0d %0d",
               first, lat, logAdr.size(), expLatency(0), NW);
    end
  endtask

`ifdef MIRE_VERIFY_EN
  task automatic test_verify();
    int lat;
    logic first;
    logic [NW-1:0] mask;
    corruptMask = NW'(1) << 3;
    applyStimulus(lat, first);
    testsRun++;
    if (errCnt !== 16'd1 || done !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL verify_word3: got err_cnt=%0d done=%b, want 1 1", errCnt, done);
    end
    for (int it = 0; it < 3; it++) begin
      mask = NW'($urandom);
      corruptMask = mask;
      applyStimulus(lat, first);
      testsRun++;
      if (errCnt !== 16'($countones(mask)) || lat != expLatency(0)) begin
        testsFailed++;
        $display("[TB] FAIL verify_rand it %0d mask %h: got err_cnt=%0d lat=%0d, want %0d %0d",
                 it, mask, errCnt, lat, $countones(mask), expLatency(0));
      end
    end
    corruptMask = '0;
  endtask
`endif

  task automatic test_restart();
    int lat;
    logic first;
    corruptMask = 16'h0081;
    applyStimulus(lat, first);
    corruptMask = '0;
    testsRun++;
    if (done !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL restart_precond: got done=%b, want 1", done);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    testsRun++;
    if ({done, busy, stb, adr} !== {1'b0, 1'b1, 1'b1, {AW{1'b0}}}) begin
      testsFailed++;
      $display("[TB] FAIL restart: got done=%b busy=%b stb=%b adr=%0d, want 0 1 1 0",
               done, busy, stb, adr);
    end
`ifdef MIRE_VERIFY_EN
    testsRun++;
    if (errCnt !== 16'h0) begin
      testsFailed++;
      $display("[TB] FAIL restart_err_clear: got err_cnt=%0d, want 0", errCnt);
    end
`endif
    for (int c = 0; c < 400 && !done; c++) @(negedge clk);
    testsRun++;
    if (done !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL restart_complete: got done=%b, want 1", done);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    test_reset();
    test_basic_fill();
    test_wait_states();
    test_random_stalls();
    test_back_to_back_start_and_reset();
`ifdef MIRE_VERIFY_EN
    test_verify();
`endif
    test_restart();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
